rd_b_fc_scaled: RTL and testbench

RD_B_FC_SCALED -- requirements
Module: rd_b_fc_scaled

---
 rtl/rd_b_fc_scaled.sv | 151 +++++++++++++++
 tb/tb_rd_b_fc_scaled.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rd_b_fc_scaled.sv
// Reads one OCH_T-channel chunk from byte-packed BRAM starting at an arbitrary channel and realigns it.
// Latency N+2 cycles from i_run to o_ot_done; a request arriving mid-read is dropped and flagged sticky.
module rd_b_fc_scaled #(
    parameter int OCH    = 120,
    parameter int OCH_B  = 8,
    parameter int I_F_BW = 8,
    localparam int OCH_T = OCH / OCH_B,
    localparam int D     = (OCH + 3) / 4,
    localparam int AW    = $clog2(D),
    localparam int IW    = $clog2(OCH)
) (
    input  logic                      clk,
    input  logic                      areset,
    input  logic                      i_run,
    input  logic [IW-1:0]             i_scaled_idx,
    output logic                      o_idle,
    output logic                      o_run,
    output logic                      o_n_ready,
    output logic                      o_en_err,
    output logic                      o_ot_done,
    output logic [OCH_T*I_F_BW-1:0]   o_ocht_scaled,
    output logic [AW-1:0]             b_o_scaled_addr,
    output logic                      b_o_scaled_ce,
    input  logic [31:0]               b_i_scaled_q
);

    // Worst case span: offset 3 plus OCH_T channels, rounded up to whole words.
    localparam int NMAX = (OCH_T + 6) / 4;
    localparam int CW   = $clog2(NMAX + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t                    state_q, state_d;
    logic [IW-1:0]             idx_q, idx_d;
    logic [CW-1:0]             n_q, n_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [AW-1:0]             addr_q, addr_d;
    logic                      ce_q, ce_d;
    logic                      vld_q;
    logic [CW-1:0]             slot_q;
    logic [NMAX-1:0][31:0]     buf_q, buf_d;
    logic [OCH_T*I_F_BW-1:0]   ocht_q, ocht_d;
    logic                      err_q, err_d;

    logic                      idx_ok, busy, accept;
    int                        need_w, avail_w;
    logic [CW-1:0]             n_w;
    logic [NMAX*32-1:0]        flat_w;
    logic [OCH_T*I_F_BW-1:0]   asm_w;

    assign idx_ok  = int'(i_scaled_idx) < OCH;
    assign busy    = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    assign accept  = i_run && idx_ok && !busy;
    assign need_w  = (int'(i_scaled_idx[1:0]) + OCH_T + 3) / 4;
    assign avail_w = D - int'(i_scaled_idx) / 4;
    assign n_w     = CW'((need_w < avail_w) ? need_w : avail_w);

    // Read data lands one cycle after its address; slot_q remembers which word it was.
    always_comb begin
        buf_d = buf_q;
        for (int w = 0; w < NMAX; w++) begin
            if (vld_q && int'(slot_q) == w) buf_d[w] = b_i_scaled_q;
        end
    end

    assign flat_w = buf_d;

    always_comb begin
        asm_w = '0;
        for (int k = 0; k < OCH_T; k++) begin
            if (int'(idx_q) + k < OCH)
                asm_w[k*I_F_BW +: I_F_BW] = I_F_BW'(flat_w[(int'(idx_q[1:0]) + k)*8 +: 8]);
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        n_d     = n_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        ce_d    = 1'b0;
        ocht_d  = ocht_q;
        err_d   = err_q;
        if (i_run && (!idx_ok || busy)) err_d = 1'b1;
        case (state_q)
            S_ISSUE: begin
                if (cnt_q < n_q) begin
                    addr_d = addr_q + AW'(1);
                    ce_d   = 1'b1;
                    cnt_d  = cnt_q + CW'(1);
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                state_d = S_DONE;
                ocht_d  = asm_w;
            end
            S_DONE:  state_d = S_IDLE;
            default: ;
        endcase
        // Accepting from DONE gives back-to-back requests with no idle gap.
        if (accept) begin
            state_d = S_ISSUE;
            idx_d   = i_scaled_idx;
            n_d     = n_w;
            cnt_d   = CW'(1);
            addr_d  = AW'(i_scaled_idx >> 2);
            ce_d    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            n_q     <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            ce_q    <= 1'b0;
            vld_q   <= 1'b0;
            slot_q  <= '0;
            buf_q   <= '0;
            ocht_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            ce_q    <= ce_d;
            vld_q   <= ce_q;
            slot_q  <= cnt_q - CW'(1);
            buf_q   <= buf_d;
            ocht_q  <= ocht_d;
            err_q   <= err_d;
        end
    end

    assign o_run           = (state_q != S_IDLE);
    assign o_idle          = !o_run;
    assign o_n_ready       = (state_q == S_DRAIN);
    assign o_ot_done       = (state_q == S_DONE);
    assign o_en_err        = err_q;
    assign o_ocht_scaled   = ocht_q;
    assign b_o_scaled_addr = addr_q;
    assign b_o_scaled_ce   = ce_q;

endmodule

// File: tb/tb_rd_b_fc_scaled.sv
// Directed bench for rd_b_fc_scaled with a 1-cycle BRAM whose byte lanes hold their channel number.
module tb_rd_b_fc_scaled;
    localparam int OCH   = 120;
    localparam int OCH_T = 15;
    localparam int AW    = 5;
    localparam int IW    = 7;
    localparam int W     = OCH_T * 8;

    logic          clk = 1'b0;
    logic          areset;
    logic          i_run;
    logic [IW-1:0] i_scaled_idx;
    logic          o_idle, o_run, o_n_ready, o_en_err, o_ot_done;
    logic [W-1:0]  o_ocht_scaled;
    logic [AW-1:0] b_o_scaled_addr;
    logic          b_o_scaled_ce;
    logic [31:0]   b_i_scaled_q = '0;

    rd_b_fc_scaled dut (
        .clk             (clk),
        .areset          (areset),
        .i_run           (i_run),
        .i_scaled_idx    (i_scaled_idx),
        .o_idle          (o_idle),
        .o_run           (o_run),
        .o_n_ready       (o_n_ready),
        .o_en_err        (o_en_err),
        .o_ot_done       (o_ot_done),
        .o_ocht_scaled   (o_ocht_scaled),
        .b_o_scaled_addr (b_o_scaled_addr),
        .b_o_scaled_ce   (b_o_scaled_ce),
        .b_i_scaled_q    (b_i_scaled_q)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (b_o_scaled_ce)
            for (int j = 0; j < 4; j++)
                b_i_scaled_q[8*j +: 8] <= 8'(4 * int'(b_o_scaled_addr) + j);
    end

    int checks = 0;
    int failures = 0;
    int a_val[$], a_cyc[$], d_cyc[$], r_cyc[$];
    logic [W-1:0] d_dat[$];
    int run_cnt, idle_bad;

    function automatic logic [W-1:0] exp_bytes(input int idx);
        logic [W-1:0] v;
        v = '0;
        for (int k = 0; k < OCH_T; k++)
            if (idx + k < OCH) v[8*k +: 8] = 8'(idx + k);
        return v;
    endfunction

    // Issue a request at cycle t, then log outputs for cycles t+1..t+ncyc.
    task automatic collect(input int idx, input int ncyc, input int rerun_c, input int rerun_idx);
        a_val.delete(); a_cyc.delete(); d_cyc.delete(); r_cyc.delete(); d_dat.delete();
        run_cnt = 0; idle_bad = 0;
        @(negedge clk);
        i_scaled_idx = IW'(idx);
        i_run = 1'b1;
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clk); #1;
            i_run = (c == rerun_c);
            if (c == rerun_c) i_scaled_idx = IW'(rerun_idx);
            if (b_o_scaled_ce) begin a_val.push_back(int'(b_o_scaled_addr)); a_cyc.push_back(c); end
            if (o_ot_done) begin d_cyc.push_back(c); d_dat.push_back(o_ocht_scaled); end
            if (o_n_ready) r_cyc.push_back(c);
            if (o_run) run_cnt++;
            if (o_idle === o_run) idle_bad++;
        end
        i_run = 1'b0;
    endtask

    task automatic test_reset();
        areset = 1'b1; i_run = 1'b0; i_scaled_idx = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({o_idle, o_run, o_n_ready, o_ot_done, o_en_err, b_o_scaled_ce} !== 6'b100000) begin
            failures++;
            $display("FAIL reset_flags got=%b want=100000",
                     {o_idle, o_run, o_n_ready, o_ot_done, o_en_err, b_o_scaled_ce});
        end
        checks++;
        if (b_o_scaled_addr !== '0 || o_ocht_scaled !== '0) begin
            failures++;
            $display("FAIL reset_data addr=%0d ocht=%h want 0/0", b_o_scaled_addr, o_ocht_scaled);
        end
        @(negedge clk); areset = 1'b0;
    endtask

    task automatic test_single(input string nm, input int idx, input int base, input int n);
        bit ok;
        collect(idx, n + 6, 0, 0);
        ok = (a_val.size() == n);
        for (int i = 0; i < a_val.size(); i++)
            if (a_val[i] != base + i || a_cyc[i] != i + 1) ok = 0;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s_addr got %0d reads first=%0d want %0d reads from %0d at t+1", nm,
                     a_val.size(), (a_val.size() > 0) ? a_val[0] : -1, n, base);
        end
        checks++;
        if (d_cyc.size() != 1 || d_cyc[0] != n + 2) begin
            failures++;
            $display("FAIL %s_done got count=%0d first=%0d want one at t+%0d", nm,
                     d_cyc.size(), (d_cyc.size() > 0) ? d_cyc[0] : -1, n + 2);
        end
        checks++;
        if (r_cyc.size() != 1 || r_cyc[0] != n + 1) begin
            failures++;
            $display("FAIL %s_nready got count=%0d first=%0d want one at t+%0d", nm,
                     r_cyc.size(), (r_cyc.size() > 0) ? r_cyc[0] : -1, n + 1);
        end
        checks++;
        if (d_dat.size() != 1 || d_dat[0] !== exp_bytes(idx)) begin
            failures++;
            $display("FAIL %s_data got=%h want=%h", nm,
                     (d_dat.size() > 0) ? d_dat[0] : '0, exp_bytes(idx));
        end
        checks++;
        if (o_ocht_scaled !== exp_bytes(idx)) begin
            failures++;
            $display("FAIL %s_hold got=%h want=%h", nm, o_ocht_scaled, exp_bytes(idx));
        end
        checks++;
        if (run_cnt != n + 2 || idle_bad != 0 || o_en_err !== 1'b0) begin
            failures++;
            $display("FAIL %s_status run_cycles=%0d idle_bad=%0d err=%b want %0d/0/0", nm,
                     run_cnt, idle_bad, o_en_err, n + 2);
        end
    endtask

    task automatic test_back_to_back();
        int exp_a[9] = '{0, 1, 2, 3, 3, 4, 5, 6, 7};
        int exp_c[9] = '{1, 2, 3, 4, 7, 8, 9, 10, 11};
        bit ok;
        collect(0, 16, 6, 15);
        ok = (a_val.size() == 9);
        for (int i = 0; i < a_val.size() && i < 9; i++)
            if (a_val[i] != exp_a[i] || a_cyc[i] != exp_c[i]) ok = 0;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL b2b_addr got %0d reads want 9 (0..3 then 3..7)", a_val.size());
        end
        checks++;
        if (d_cyc.size() != 2 || d_cyc[0] != 6 || d_cyc[1] != 13) begin
            failures++;
            $display("FAIL b2b_done got count=%0d want t+6 and t+13", d_cyc.size());
        end
        checks++;
        if (r_cyc.size() != 2 || r_cyc[0] != 5 || r_cyc[1] != 12) begin
            failures++;
            $display("FAIL b2b_nready got count=%0d want t+5 and t+12", r_cyc.size());
        end
        checks++;
        if (d_dat.size() != 2 || d_dat[0] !== exp_bytes(0) || d_dat[1] !== exp_bytes(15)) begin
            failures++;
            $display("FAIL b2b_data got=%h want=%h", (d_dat.size() > 1) ? d_dat[1] : '0, exp_bytes(15));
        end
        checks++;
        if (o_en_err !== 1'b0 || run_cnt != 13) begin
            failures++;
            $display("FAIL b2b_status err=%b run_cycles=%0d want 0/13", o_en_err, run_cnt);
        end
    endtask

    task automatic test_errors();
        collect(0, 10, 2, 40);
        checks++;
        if (a_val.size() != 4 || d_cyc.size() != 1 || d_cyc[0] != 6) begin
            failures++;
            $display("FAIL busy_run_ignored reads=%0d dones=%0d want 4/1 at t+6", a_val.size(), d_cyc.size());
        end
        checks++;
        if (d_dat.size() != 1 || d_dat[0] !== exp_bytes(0)) begin
            failures++;
            $display("FAIL busy_run_data got=%h want=%h", (d_dat.size() > 0) ? d_dat[0] : '0, exp_bytes(0));
        end
        checks++;
        if (o_en_err !== 1'b1) begin
            failures++;
            $display("FAIL busy_run_err got=%b want=1", o_en_err);
        end
        collect(120, 6, 0, 0);
        checks++;
        if (a_val.size() != 0 || d_cyc.size() != 0 || run_cnt != 0) begin
            failures++;
            $display("FAIL bad_idx reads=%0d dones=%0d run=%0d want 0/0/0", a_val.size(), d_cyc.size(), run_cnt);
        end
        checks++;
        if (o_en_err !== 1'b1 || o_idle !== 1'b1) begin
            failures++;
            $display("FAIL bad_idx_err err=%b idle=%b want 1/1", o_en_err, o_idle);
        end
    endtask

    task automatic test_areset_mid();
        int bad;
        @(negedge clk); i_scaled_idx = '0; i_run = 1'b1;
        @(posedge clk); #1;
        i_run = 1'b0; areset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({o_idle, o_run, o_n_ready, o_ot_done, o_en_err, b_o_scaled_ce} !== 6'b100000
            || b_o_scaled_addr !== '0 || o_ocht_scaled !== '0) begin
            failures++;
            $display("FAIL abort_reset flags=%b addr=%0d ocht=%h want 100000/0/0",
                     {o_idle, o_run, o_n_ready, o_ot_done, o_en_err, b_o_scaled_ce},
                     b_o_scaled_addr, o_ocht_scaled);
        end
        @(negedge clk); areset = 1'b0;
        bad = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (o_ot_done || b_o_scaled_ce || o_run) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL abort_quiet got %0d active cycles want 0", bad);
        end
        collect(0, 10, 0, 0);
        checks++;
        if (d_cyc.size() != 1 || d_cyc[0] != 6 || d_dat[0] !== exp_bytes(0)) begin
            failures++;
            $display("FAIL abort_recover dones=%0d data=%h want one at t+6 data=%h",
                     d_cyc.size(), (d_dat.size() > 0) ? d_dat[0] : '0, exp_bytes(0));
        end
    endtask

    initial begin
        test_reset();
        test_single("idx0", 0, 0, 4);
        test_single("idx7", 7, 1, 5);
        test_single("idx110", 110, 27, 3);
        test_back_to_back();
        test_errors();
        test_areset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
